bit_serial_subtractor: RTL and testbench
========================================

// Module: bit_serial_subtractor
// PURPOSE
//  Sequential inverse of the combinational half-adder datapath: computes
//  unsigned A - B one bit per clock, LSB first, with a borrow flip-flop.
//  Instantiated under the tt_um_* top; operands come from ui_in / uio_in,
//  result and status go to uo_out. Start/busy/done handshake to the top.
// PARAMETERS
//  WIDTH  8  operand and result width in bits (legal range 2..16)
// PORTS
//  clk     in   1      clock; all state updates on rising edge
//  rst_n   in   1      reset, synchronous, active-low
//  ena     in   1      clock enable; 0 = all state held
//  start   in   1      request; sampled only when ready=1
//  a       in   WIDTH  minuend, latched on start acceptance
//  b       in   WIDTH  subtrahend, latched on start acceptance
//  ready   out  1      1 in IDLE and DONE (can accept start)
//  busy    out  1      1 while in SHIFT
//  done    out  1      single-cycle pulse, result valid
//  diff    out  WIDTH  (a - b) mod 2^WIDTH, held until next acceptance
//  borrow  out  1      1 iff a < b (unsigned), held with diff
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, shift regs, bit counter, borrow FF,
//    diff, borrow, done, busy = 0; ready=1. Aborts any operation in flight.
//  - ena=0: no state, counter or output register changes; done stays as is.
//  - States: IDLE -> SHIFT (start & ready) ; SHIFT -> DONE (cnt==WIDTH-1);
//    DONE -> SHIFT (start) else DONE -> IDLE. No other transitions.
//  - Acceptance edge: latch a,b into shift regs, cnt=0, borrow FF=0,
//    diff/borrow outputs keep old values until the new result completes.
//  - SHIFT, each edge: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
//    shift d into result MSB, shift a,b right, bin <= bout, cnt++.
//  - Edge that processes bit WIDTH-1: diff <= full result, borrow <= bout,
//    state=DONE, done=1 for exactly one cycle. Latency: done high in the
//    cycle following the WIDTH-th edge after acceptance (WIDTH cycles).
//  - start while busy: ignored, no effect on operands or timing.
//  - start in DONE cycle: accepted (back-to-back); done still pulses once.
//  - Wrap: result is modulo 2^WIDTH; borrow carries the sign, no saturation.
//  - Counter width: $clog2(WIDTH); no overflow past WIDTH-1 by construction.
//  - busy = (state==SHIFT); ready = ~busy; outputs registered or state-decoded,
//    no combinational path from a/b to any output.
// STRUCTURE
//  - Shared package: state encoding localparams (S_IDLE=2'd0, S_SHIFT=2'd1,
//    S_DONE=2'd2) and default WIDTH constant, reused by the top and bench.
//  - One sub-module: half_subtractor_d (a, b -> diff, borrow), mirror of
//    half_adder_d; two instances plus an OR form the per-bit full subtractor.
//  - Remainder: FSM, counter, operand/result shift registers in this module.
// TESTING
//  1. a=200, b=55, start 1 cycle -> done after 8 cycles, diff=145, borrow=0.
//  2. a=5, b=9 -> diff=252, borrow=1; busy high exactly 8 cycles.
//  3. a=0,b=1 -> 255/borrow=1; then a=0,b=0 back-to-back in DONE cycle
//     -> second done 8 cycles later, diff=0, borrow=0; one done pulse each.
//  4. start pulsed mid-SHIFT with a=1,b=1 -> ignored; result of first op intact.
//  5. rst_n=0 at cycle 4 of SHIFT -> next cycle all outputs 0, ready=1,
//     no done pulse; fresh op 7-3 afterwards -> diff=4.
//  6. ena=0 for 3 cycles mid-SHIFT -> done delayed by exactly 3 cycles, result
//     correct; random 1000-op compare against a - b reference model.

Source files
------------

// File: rtl/bit_serial_subtractor_pkg.sv
// bit_serial_subtractor_pkg: shared FSM state encoding and default operand width.
package bit_serial_subtractor_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bit_serial_subtractor_if.sv
// bit_serial_subtractor_if: start/busy/done handshake plus operand and result buses.
interface bit_serial_subtractor_if
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  modport master (output start, a, b, input ready, busy, done, diff, borrow);
  modport slave (input start, a, b, output ready, busy, done, diff, borrow);
endinterface

// File: rtl/bit_serial_subtractor_half_subtractor_d.sv
// half_subtractor_d: one-bit a - b, the subtracting mirror of half_adder_d.
module half_subtractor_d (
  input  logic i_a,
  input  logic i_b,
  output logic o_diff,
  output logic o_borrow
);
  assign o_diff   = i_a ^ i_b;
  assign o_borrow = ~i_a & i_b;
endmodule

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: unsigned a - b computed LSB first, one bit per enabled clock.
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   ena,
  bit_serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_bin, r_borrow, r_done;
  logic             w_d1, w_b1, w_d, w_b2, w_bout;
  logic [WIDTH-1:0] w_res;
  // two half subtractors plus an OR form the full subtractor for the current bit
  half_subtractor_d u_hs0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_diff(w_d1), .o_borrow(w_b1));
  half_subtractor_d u_hs1 (.i_a(w_d1), .i_b(r_bin), .o_diff(w_d), .o_borrow(w_b2));
  assign w_bout     = w_b1 | w_b2;
  assign w_res      = {w_d, r_res};
  assign bus.busy   = r_state == S_SHIFT;
  assign bus.ready  = r_state != S_SHIFT;
  assign bus.done   = r_done;
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res[WIDTH-1:1];
          r_bin <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_diff   <= w_res;
            r_borrow <= w_bout;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_res   <= '0;
            r_cnt   <= '0;
            r_bin   <= 1'b0;
            r_state <= S_SHIFT;
          end else r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb_bit_serial_subtractor: vector table, corner sequences and random ops checked through a result queue.
module tb_bit_serial_subtractor;
  import bit_serial_subtractor_pkg::*;
  localparam int W = DEF_WIDTH;
  typedef struct {logic [W-1:0] a, b, d; logic br;} vec_t;
  typedef struct {logic [W-1:0] d; logic br;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic prev_done = 1'b0;
  int checks = 0, errors = 0, n_done = 0;
  exp_t sb[$];
  vec_t vecs[10];
  always #5 clk = ~clk;
  bit_serial_subtractor_if #(.WIDTH(W)) bif ();
  bit_serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bif));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    model.d  = a - b;
    model.br = a < b;
  endfunction
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d, input logic br);
    exp_t e;
    e.d = d;
    e.br = br;
    bif.start = 1'b1;
    bif.a = a;
    bif.b = b;
    sb.push_back(e);
    tick;
    bif.start = 1'b0;
  endtask
  task automatic wait_done(output int c, output int bc);
    c = 0;
    bc = bif.busy ? 1 : 0;
    while (!bif.done && c < 64) begin
      tick;
      c++;
      if (bif.busy) bc++;
    end
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d, input logic br, input string nm);
    int c, bc;
    issue(a, b, d, br);
    wait_done(c, bc);
    chk({nm, "_latency"}, c, W);
    chk({nm, "_busy_cycles"}, bc, W);
    tick;
    chk({nm, "_done_pulse"}, int'(bif.done), 0);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bif.done && !prev_done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 diff=%0d expected no pending result", bif.diff);
      end else begin
        e = sb.pop_front();
        chk("diff", int'(bif.diff), int'(e.d));
        chk("borrow", int'(bif.borrow), int'(e.br));
      end
    end
    prev_done = bif.done;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int c, bc, n0;
    logic [W-1:0] ra, rb;
    exp_t m;
    vecs[0] = '{8'd200, 8'd55, 8'd145, 1'b0};
    vecs[1] = '{8'd5, 8'd9, 8'd252, 1'b1};
    vecs[2] = '{8'd0, 8'd1, 8'd255, 1'b1};
    vecs[3] = '{8'd0, 8'd0, 8'd0, 1'b0};
    vecs[4] = '{8'd255, 8'd255, 8'd0, 1'b0};
    vecs[5] = '{8'd255, 8'd0, 8'd255, 1'b0};
    vecs[6] = '{8'd0, 8'd255, 8'd1, 1'b1};
    vecs[7] = '{8'd7, 8'd3, 8'd4, 1'b0};
    vecs[8] = '{8'd128, 8'd1, 8'd127, 1'b0};
    vecs[9] = '{8'd1, 8'd128, 8'd129, 1'b1};
    bif.start = 1'b0;
    bif.a = '0;
    bif.b = '0;
    repeat (2) tick;
    chk("rst_ready", int'(bif.ready), 1);
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_done", int'(bif.done), 0);
    chk("rst_diff", int'(bif.diff), 0);
    chk("rst_borrow", int'(bif.borrow), 0);
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, $sformatf("vec%0d", i));
    n0 = n_done;
    issue(8'd0, 8'd1, 8'd255, 1'b1);
    wait_done(c, bc);
    chk("b2b_first_latency", c, W);
    issue(8'd0, 8'd0, 8'd0, 1'b0);
    chk("b2b_done_drop", int'(bif.done), 0);
    chk("b2b_busy", int'(bif.busy), 1);
    wait_done(c, bc);
    chk("b2b_second_latency", c, W);
    tick;
    chk("b2b_done_count", n_done - n0, 2);
    issue(8'd200, 8'd55, 8'd145, 1'b0);
    repeat (2) tick;
    bif.start = 1'b1;
    bif.a = 8'd1;
    bif.b = 8'd1;
    tick;
    bif.start = 1'b0;
    chk("ignore_busy", int'(bif.busy), 1);
    wait_done(c, bc);
    chk("ignore_latency", c + 3, W);
    tick;
    n0 = n_done;
    issue(8'd100, 8'd1, 8'd99, 1'b0);
    repeat (3) tick;
    rst_n = 1'b0;
    tick;
    chk("abort_ready", int'(bif.ready), 1);
    chk("abort_busy", int'(bif.busy), 0);
    chk("abort_done", int'(bif.done), 0);
    chk("abort_diff", int'(bif.diff), 0);
    chk("abort_borrow", int'(bif.borrow), 0);
    rst_n = 1'b1;
    sb.delete();
    repeat (12) tick;
    chk("abort_no_done", n_done - n0, 0);
    run_op(8'd7, 8'd3, 8'd4, 1'b0, "after_abort");
    issue(8'd170, 8'd85, 8'd85, 1'b0);
    repeat (2) tick;
    ena = 1'b0;
    repeat (3) tick;
    chk("stall_busy", int'(bif.busy), 1);
    ena = 1'b1;
    wait_done(c, bc);
    chk("stall_latency", c + 5, W + 3);
    tick;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      m = model(ra, rb);
      run_op(ra, rb, m.d, m.br, "rand");
    end
    tick;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
